add_xor_shift_pipe: RTL and testbench
=====================================

// Module: add_xor_shift_pipe
// PURPOSE
// Streaming, parametrised add -> xor -> shift transform engine for the crypto challenge toolkit.
// Each accepted beat carries its own operand, add key, xor key, shift amount and shift mode.
// Three registered stages run under a valid/ready handshake; one result is produced per cycle when not stalled.
// A tag travels with each beat, and a 32-bit counter tracks completed results.
// PARAMETERS
// WIDTH  64  datapath width in bits; must be >= 2.
// TAG_W  4   width of the opaque tag carried with each beat.
// SH_W   $clog2(WIDTH)  shift-amount width; derived, not to be overridden.
// PORTS
// clk        in   1      single clock, rising edge
// rst        in   1      synchronous, active-high reset
// in_valid   in   1      input beat valid
// in_ready   out  1      input beat accepted when in_valid && in_ready
// in_data    in   WIDTH  operand
// in_add_k   in   WIDTH  addend for stage 1
// in_xor_k   in   WIDTH  xor mask for stage 2
// in_shamt   in   SH_W   shift amount for stage 3
// in_mode    in   2      00 SHR logical, 01 SHL, 10 ROR, 11 PASS (no shift)
// in_tag     in   TAG_W  opaque tag
// out_valid  out  1      result valid
// out_ready  in   1      downstream accepts when out_valid && out_ready
// out_data   out  WIDTH  transformed result
// out_tag    out  TAG_W  tag of this result
// out_count  out  32     number of completed output handshakes
// BEHAVIOUR
// - Reset (sync, rst=1 at a clk edge): all stage valids=0, out_valid=0, out_data=0, out_tag=0, out_count=0; in_ready is 1 in the first cycle after reset.
// - Reset mid-operation flushes every in-flight beat; flushed beats are never output and are not counted.
// - Pipeline: S1 r1 = in_data + in_add_k (mod 2^WIDTH, carry out discarded); S2 r2 = r1 ^ xor_k; S3 shift per mode.
// - Shift rules: SHR zero-fills at the MSB; SHL zero-fills at the LSB; ROR rotates right; PASS ignores shamt; shamt=0 gives identity in every mode.
// - xor_k, shamt, mode and tag are registered with the beat and travel with it; inputs are sampled only on handshake.
// - Latency: 3 cycles from an accepted input beat to out_valid when there is no stall. Throughput is 1 beat per cycle.
// - Stall: global enable adv = !out_valid || out_ready; in_ready = adv (combinational). When adv=0 all stages hold and out_data/out_tag stay stable.
// - Bubbles: a stage whose valid=0 still advances on adv; the bench checks no bubble-collapse behaviour.
// - Same-cycle output handshake and input acceptance are both allowed; the pipeline shifts by one stage.
// - out_count increments by 1 on each out_valid && out_ready; wraps 0xFFFFFFFF -> 0 with no flag.
// - out_valid never falls without a handshake (AXI-style stability); data and tag are unchanged while stalled.
// STRUCTURE
// - Package axs_pkg: mode localparams (AXS_SHR=2'd0, AXS_SHL=2'd1, AXS_ROR=2'd2, AXS_PASS=2'd3);
//   default keys AXS_ADD_K=64'h12345678, AXS_XOR_K=64'h4841434B45525321 ("HACKERS!"), AXS_SHAMT=5.
// - Sub-module axs_shifter: combinational WIDTH/SH_W shifter with mode input, used in S3; must be unit-testable alone.
// - Top: three stage registers with valid bits, global adv, output counter.
// TESTING
// - Single beat, WIDTH=64: data=64'h5443474D489DFDD3, add=AXS_ADD_K, xor=AXS_XOR_K, shamt=5, SHR -> out 64'h00E0102030FC003B after 3 cycles.
// - Same operands, mode ROR -> 64'h50E0102030FC003B; mode SHL -> 64'h804080C3F000ED40; mode PASS -> 64'h1C0204061F80076A.
// - Add overflow: data=all-ones, add=1, xor=0, shamt=0, SHR -> out 0 (carry discarded).
// - Back-to-back 8 beats with tags 0..7 and out_ready=1 -> 8 results on consecutive cycles, in order; out_count=8.
// - Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_data/out_tag stable; after release all beats emerge in order, none lost.
// - Assert rst with 2 beats in flight -> next cycle out_valid=0, out_count=0; a new beat after reset emerges 3 cycles later with the correct value.

Source files
------------

// File: rtl/axs_pkg.sv
// rtl/axs_pkg.sv - shared constants for the add/xor/shift stream engine
package axs_pkg;

   // shift mode encodings carried with each beat
   localparam logic [1:0] AXS_SHR  = 2'd0;
   localparam logic [1:0] AXS_SHL  = 2'd1;
   localparam logic [1:0] AXS_ROR  = 2'd2;
   localparam logic [1:0] AXS_PASS = 2'd3;

   // default challenge keys ("HACKERS!" as the xor key)
   localparam logic [63:0] AXS_ADD_K = 64'h0000_0000_1234_5678;
   localparam logic [63:0] AXS_XOR_K = 64'h4841_434B_4552_5321;
   localparam int          AXS_SHAMT = 5;

endpackage

// File: rtl/axs_shifter.sv
// rtl/axs_shifter.sv - combinational shifter used in the last pipeline stage
// Ports:
//   data   : value to shift
//   shamt  : shift amount
//   mode   : AXS_SHR / AXS_SHL / AXS_ROR / AXS_PASS
//   result : shifted value
module axs_shifter #(
   parameter int WIDTH = 64,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [SH_W-1:0]  shamt,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] result
);
   import axs_pkg::*;

   always_comb begin
      result = data;
      case (mode)
         AXS_SHR: result = data >> shamt;
         AXS_SHL: result = data << shamt;
         // left term shifts by WIDTH when shamt=0 and so contributes zero
         AXS_ROR: result = (data >> shamt) | (data << (WIDTH - int'(shamt)));
         default: result = data;
      endcase
   end

endmodule

// File: rtl/add_xor_shift_pipe.sv
// rtl/add_xor_shift_pipe.sv - three-stage add -> xor -> shift stream transform
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : input handshake; in_data, in_add_k, in_xor_k,
//                       in_shamt, in_mode, in_tag sampled on handshake
//   out_valid/out_ready : output handshake; out_data, out_tag result
//   out_count         : completed output handshakes (wraps)
module add_xor_shift_pipe #(
   parameter  int WIDTH = 64,
   parameter  int TAG_W = 4,
   localparam int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_add_k,
   input  logic [WIDTH-1:0] in_xor_k,
   input  logic [SH_W-1:0]  in_shamt,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic [31:0]      out_count
);
   import axs_pkg::*;

   // one enable for the whole pipe: it moves only when the output slot frees
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // stage 1: sum plus the side-band that travels with it
   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [WIDTH-1:0] s1_xor_k;
   logic [SH_W-1:0]  s1_shamt;
   logic [1:0]       s1_mode;
   logic [TAG_W-1:0] s1_tag;

   // stage 2: xored value
   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;
   logic [SH_W-1:0]  s2_shamt;
   logic [1:0]       s2_mode;
   logic [TAG_W-1:0] s2_tag;

   logic [WIDTH-1:0] sh_result;

   axs_shifter #(.WIDTH(WIDTH), .SH_W(SH_W)) u_shifter (
      .data   (s2_data),
      .shamt  (s2_shamt),
      .mode   (s2_mode),
      .result (sh_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_xor_k  <= '0;
         s1_shamt  <= '0;
         s1_mode   <= AXS_PASS;
         s1_tag    <= '0;
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_shamt  <= '0;
         s2_mode   <= AXS_PASS;
         s2_tag    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_count <= '0;
      end else begin
         if (out_valid && out_ready)
            out_count <= out_count + 32'd1;
         if (adv) begin
            // bubbles advance too; side-band only captured on a real handshake
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_data  <= in_data + in_add_k;
               s1_xor_k <= in_xor_k;
               s1_shamt <= in_shamt;
               s1_mode  <= in_mode;
               s1_tag   <= in_tag;
            end
            s2_valid  <= s1_valid;
            s2_data   <= s1_data ^ s1_xor_k;
            s2_shamt  <= s1_shamt;
            s2_mode   <= s1_mode;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_data  <= sh_result;
            out_tag   <= s2_tag;
         end
      end
   end

endmodule

// File: tb/tb_add_xor_shift_pipe.sv
// tb/tb_add_xor_shift_pipe.sv - scoreboard bench for add_xor_shift_pipe
module tb_add_xor_shift_pipe;
   import axs_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [63:0] in_add_k;
   logic [63:0] in_xor_k;
   logic [5:0]  in_shamt;
   logic [1:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  out_tag;
   logic [31:0] out_count;

   add_xor_shift_pipe #(.WIDTH(64), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_add_k  (in_add_k),
      .in_xor_k  (in_xor_k),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic [3:0]  t;
   } exp_t;

   exp_t q[$];
   int   out_cycs[$];
   int   cyc = 0;
   int   last_accept = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: pop and compare on every output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_output", {60'd0, out_tag}, 64'hFFFF);
         end else begin
            check("out_data", out_data, q[0].d);
            check("out_tag", {60'd0, out_tag}, {60'd0, q[0].t});
            void'(q.pop_front());
         end
         out_cycs.push_back(cyc);
      end
   end

   task automatic send(input logic [63:0] d, input logic [63:0] a, input logic [63:0] x,
                       input logic [5:0] sh, input logic [1:0] m, input logic [3:0] t,
                       input logic [63:0] exp);
      logic ok;
      int   n;
      exp_t e;
      in_data  = d;
      in_add_k = a;
      in_xor_k = x;
      in_shamt = sh;
      in_mode  = m;
      in_tag   = t;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      else begin
         e.d = exp;
         e.t = t;
         q.push_back(e);
         last_accept = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
   endtask

   localparam logic [63:0] VEC = 64'h5443474D489DFDD3;

   initial begin
      int idx0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_add_k = '0; in_xor_k = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
      do_reset();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_tag", {60'd0, out_tag}, 64'd0);
      check("rst_out_count", {32'd0, out_count}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // reference vector in each mode
      send(VEC, AXS_ADD_K, AXS_XOR_K, 6'd5, AXS_SHR, 4'd1, 64'h00E0102030FC003B);
      drain("drain_shr");
      check("latency", 64'(out_cycs[out_cycs.size()-1] - last_accept + 1), 64'd3);
      send(VEC, AXS_ADD_K, AXS_XOR_K, 6'd5, AXS_ROR,  4'd2, 64'h50E0102030FC003B);
      send(VEC, AXS_ADD_K, AXS_XOR_K, 6'd5, AXS_SHL,  4'd3, 64'h804080C3F000ED40);
      send(VEC, AXS_ADD_K, AXS_XOR_K, 6'd5, AXS_PASS, 4'd4, 64'h1C0204061F80076A);
      // boundaries: carry discarded, zero shift identity, extreme shifts
      send(64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 6'd0, AXS_SHR, 4'd5, 64'd0);
      send(64'h0123456789ABCDEF, 64'd0, 64'd0, 6'd0, AXS_ROR, 4'd6, 64'h0123456789ABCDEF);
      send(64'h8000000000000000, 64'd0, 64'd0, 6'd63, AXS_SHR, 4'd7, 64'd1);
      send(64'd1, 64'd0, 64'd0, 6'd1, AXS_ROR, 4'd8, 64'h8000000000000000);
      send(64'd1, 64'd0, 64'd0, 6'd63, AXS_SHL, 4'd9, 64'h8000000000000000);
      drain("drain_modes");
      check("count_modes", {32'd0, out_count}, 64'd9);

      // back-to-back burst of 8
      do_reset();
      idx0 = out_cycs.size();
      for (int i = 0; i < 8; i++)
         send(64'(i) << 8, 64'h10, 64'hFF, 6'd4, AXS_SHL, 4'(i), (64'(i) << 12) | 64'hEF0);
      drain("drain_burst");
      check("burst_outputs", 64'(out_cycs.size() - idx0), 64'd8);
      if (out_cycs.size() - idx0 == 8)
         check("burst_consecutive", 64'(out_cycs[idx0+7] - out_cycs[idx0]), 64'd7);
      check("burst_count", {32'd0, out_count}, 64'd8);

      // backpressure with full pipe
      out_ready = 1'b0;
      for (int j = 1; j <= 3; j++)
         send(64'(j) << 8, 64'd0, 64'd0, 6'd1, AXS_SHR, 4'(j + 8), 64'(j) << 7);
      for (int k = 0; k < 5; k++) begin
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_out_valid", {63'd0, out_valid}, 64'd1);
         check("stall_out_data", out_data, 64'h80);
         check("stall_out_tag", {60'd0, out_tag}, 64'd9);
         @(posedge clk);
         #1;
      end
      check("stall_count", {32'd0, out_count}, 64'd8);
      out_ready = 1'b1;
      send(64'h400, 64'd0, 64'd0, 6'd1, AXS_SHR, 4'd12, 64'h200);
      drain("drain_stall");
      check("stall_final_count", {32'd0, out_count}, 64'd12);

      // reset with two beats in flight
      send(64'hAAAA, 64'd0, 64'd0, 6'd0, AXS_PASS, 4'd13, 64'hAAAA);
      send(64'hBBBB, 64'd0, 64'd0, 6'd0, AXS_PASS, 4'd14, 64'hBBBB);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_count", {32'd0, out_count}, 64'd0);
      rst = 1'b0;
      q.delete();
      send(VEC, AXS_ADD_K, AXS_XOR_K, 6'd5, AXS_SHR, 4'd15, 64'h00E0102030FC003B);
      drain("drain_after_rst");
      check("after_rst_latency", 64'(out_cycs[out_cycs.size()-1] - last_accept + 1), 64'd3);
      check("after_rst_count", {32'd0, out_count}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
